// File: rtl/cuckoo_pkg.sv
// Shared defaults and encodings for the cuckoo table bank.
// Optional occupancy counters are enabled with CUCKOO_OCCUPANCY_EN.
package cuckoo_pkg;

    localparam int unsigned DEPTH_DEF = 11;
    localparam int unsigned IDX_W_DEF = 5;
    localparam int unsigned KEY_W_DEF = 32;

    typedef enum logic {
        OP_INSERT = 1'b0,
        OP_LOOKUP = 1'b1
    } op_e;

    typedef enum logic {
        TBL1 = 1'b0,
        TBL2 = 1'b1
    } tbl_e;

endpackage

// File: rtl/cuckoo_table_bank_if.sv
// Request/response bundle of the cuckoo table bank.
// occ1/occ2 exist only when CUCKOO_OCCUPANCY_EN is defined.
interface cuckoo_table_bank_if
    import cuckoo_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF,
    parameter int unsigned KEY_W = KEY_W_DEF
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic             req_valid;
    logic             req_op;
    logic             req_tbl;
    logic [KEY_W-1:0] req_key;
    logic             rsp_valid;
    logic [IDX_W-1:0] rsp_idx;
    logic             evict_valid;
    logic [KEY_W-1:0] evict_key;
    logic             hit;
    logic             hit_tbl;
`ifdef CUCKOO_OCCUPANCY_EN
    logic [OCC_W-1:0] occ1;
    logic [OCC_W-1:0] occ2;
`endif

    modport master (
`ifdef CUCKOO_OCCUPANCY_EN
        input  occ1,
        input  occ2,
`endif
        output req_valid,
        output req_op,
        output req_tbl,
        output req_key,
        input  rsp_valid,
        input  rsp_idx,
        input  evict_valid,
        input  evict_key,
        input  hit,
        input  hit_tbl
    );

    modport slave (
`ifdef CUCKOO_OCCUPANCY_EN
        output occ1,
        output occ2,
`endif
        input  req_valid,
        input  req_op,
        input  req_tbl,
        input  req_key,
        output rsp_valid,
        output rsp_idx,
        output evict_valid,
        output evict_key,
        output hit,
        output hit_tbl
    );

endinterface

// File: rtl/cuckoo_hash_unit.sv
// Combinational hash pair: h1 = key mod DEPTH, h2 = (key / DEPTH) mod DEPTH.
module cuckoo_hash_unit
    import cuckoo_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF,
    parameter int unsigned KEY_W = KEY_W_DEF
) (
    input  logic [KEY_W-1:0] key_i,
    output logic [IDX_W-1:0] h1_o,
    output logic [IDX_W-1:0] h2_o
);

    logic [KEY_W-1:0] quot;

    assign quot = key_i / KEY_W'(DEPTH);
    assign h1_o = IDX_W'(key_i % KEY_W'(DEPTH));
    assign h2_o = IDX_W'(quot % KEY_W'(DEPTH));

endmodule

// File: rtl/cuckoo_table_bank.sv
// Two-table cuckoo storage bank with eviction reporting and lookup.
// Define CUCKOO_OCCUPANCY_EN to add per-table filled-slot counters.
module cuckoo_table_bank
    import cuckoo_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF,
    parameter int unsigned KEY_W = KEY_W_DEF
) (
    input logic                clk,
    input logic                rst_n,
    cuckoo_table_bank_if.slave bus
);

    logic [IDX_W-1:0] h1, h2;

    cuckoo_hash_unit #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .KEY_W (KEY_W)
    ) u_hash (
        .key_i (bus.req_key),
        .h1_o  (h1),
        .h2_o  (h2)
    );

    logic [KEY_W-1:0] tbl1_q [DEPTH];
    logic [KEY_W-1:0] tbl1_d [DEPTH];
    logic [KEY_W-1:0] tbl2_q [DEPTH];
    logic [KEY_W-1:0] tbl2_d [DEPTH];
    logic [DEPTH-1:0] filled1_q, filled1_d, filled2_q, filled2_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
    logic             evict_valid_q, evict_valid_d;
    logic [KEY_W-1:0] evict_key_q, evict_key_d;
    logic             hit_q, hit_d;
    logic             hit_tbl_q, hit_tbl_d;

    // Slot contents addressed by the current hashes (loop select avoids index-width games).
    logic [KEY_W-1:0] slot1_key, slot2_key;
    logic             slot1_full, slot2_full;

    always_comb begin
        slot1_key  = '0;
        slot2_key  = '0;
        slot1_full = 1'b0;
        slot2_full = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (h1 == IDX_W'(i)) begin
                slot1_key  = tbl1_q[i];
                slot1_full = filled1_q[i];
            end
            if (h2 == IDX_W'(i)) begin
                slot2_key  = tbl2_q[i];
                slot2_full = filled2_q[i];
            end
        end
    end

    logic match1, match2;
    assign match1 = slot1_full && (slot1_key == bus.req_key);
    assign match2 = slot2_full && (slot2_key == bus.req_key);

`ifdef CUCKOO_OCCUPANCY_EN
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    logic [OCC_W-1:0] occ1_q, occ1_d, occ2_q, occ2_d;
`endif

    always_comb begin
        tbl1_d        = tbl1_q;
        tbl2_d        = tbl2_q;
        filled1_d     = filled1_q;
        filled2_d     = filled2_q;
        rsp_valid_d   = 1'b0;
        rsp_idx_d     = rsp_idx_q;
        evict_valid_d = evict_valid_q;
        evict_key_d   = evict_key_q;
        hit_d         = hit_q;
        hit_tbl_d     = hit_tbl_q;
`ifdef CUCKOO_OCCUPANCY_EN
        occ1_d        = occ1_q;
        occ2_d        = occ2_q;
`endif
        if (bus.req_valid) begin
            rsp_valid_d = 1'b1;
            if (bus.req_op == OP_INSERT) begin
                hit_d     = 1'b0;
                hit_tbl_d = 1'b0;
                if (bus.req_tbl == TBL1) begin
                    rsp_idx_d     = h1;
                    evict_valid_d = slot1_full;
                    evict_key_d   = slot1_full ? slot1_key : '0;
`ifdef CUCKOO_OCCUPANCY_EN
                    if (!slot1_full) occ1_d = occ1_q + OCC_W'(1);
`endif
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (h1 == IDX_W'(i)) begin
                            tbl1_d[i]    = bus.req_key;
                            filled1_d[i] = 1'b1;
                        end
                    end
                end else begin
                    rsp_idx_d     = h2;
                    evict_valid_d = slot2_full;
                    evict_key_d   = slot2_full ? slot2_key : '0;
`ifdef CUCKOO_OCCUPANCY_EN
                    if (!slot2_full) occ2_d = occ2_q + OCC_W'(1);
`endif
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (h2 == IDX_W'(i)) begin
                            tbl2_d[i]    = bus.req_key;
                            filled2_d[i] = 1'b1;
                        end
                    end
                end
            end else begin
                evict_valid_d = 1'b0;
                evict_key_d   = '0;
                hit_d         = match1 | match2;
                hit_tbl_d     = !match1 && match2;
                rsp_idx_d     = match1 ? h1 : (match2 ? h2 : '0);
            end
        end
    end

    // Key storage needs no reset: the filled vectors gate every use of it.
    always_ff @(posedge clk) begin
        tbl1_q <= tbl1_d;
        tbl2_q <= tbl2_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filled1_q     <= '0;
            filled2_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_idx_q     <= '0;
            evict_valid_q <= 1'b0;
            evict_key_q   <= '0;
            hit_q         <= 1'b0;
            hit_tbl_q     <= 1'b0;
`ifdef CUCKOO_OCCUPANCY_EN
            occ1_q        <= '0;
            occ2_q        <= '0;
`endif
        end else begin
            filled1_q     <= filled1_d;
            filled2_q     <= filled2_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_idx_q     <= rsp_idx_d;
            evict_valid_q <= evict_valid_d;
            evict_key_q   <= evict_key_d;
            hit_q         <= hit_d;
            hit_tbl_q     <= hit_tbl_d;
`ifdef CUCKOO_OCCUPANCY_EN
            occ1_q        <= occ1_d;
            occ2_q        <= occ2_d;
`endif
        end
    end

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_idx     = rsp_idx_q;
    assign bus.evict_valid = evict_valid_q;
    assign bus.evict_key   = evict_key_q;
    assign bus.hit         = hit_q;
    assign bus.hit_tbl     = hit_tbl_q;
`ifdef CUCKOO_OCCUPANCY_EN
    assign bus.occ1        = occ1_q;
    assign bus.occ2        = occ2_q;
`endif

endmodule

// File: tb/tb_cuckoo_table_bank.sv
// Bench for cuckoo_table_bank: directed scenarios then random traffic against a slot-array model.
module tb_cuckoo_table_bank;
    import cuckoo_pkg::*;

    localparam int unsigned DEPTH = 11;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned KEY_W = 32;

    logic clk;
    logic rst_n;

    cuckoo_table_bank_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .KEY_W(KEY_W)) bus ();

    cuckoo_table_bank #(.DEPTH(DEPTH), .IDX_W(IDX_W), .KEY_W(KEY_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: tables as plain arrays, plus the expected output registers.
    logic [31:0] m_t1 [DEPTH];
    logic [31:0] m_t2 [DEPTH];
    bit          m_f1 [DEPTH];
    bit          m_f2 [DEPTH];
    int unsigned m_occ1 = 0, m_occ2 = 0;
    bit          e_valid = 0, e_ev = 0, e_hit = 0, e_htbl = 0;
    int unsigned e_idx = 0;
    logic [31:0] e_evk = '0;

    task automatic step(input bit v, input bit op, input bit tbl, input logic [31:0] key,
                        input bit rstn);
        int unsigned h1, h2;
        bit m1, m2;
        @(negedge clk);
        check_eq("rsp_valid", bus.rsp_valid, e_valid);
        check_eq("rsp_idx", bus.rsp_idx, e_idx);
        check_eq("evict_valid", bus.evict_valid, e_ev);
        check_eq("evict_key", bus.evict_key, e_evk);
        check_eq("hit", bus.hit, e_hit);
        check_eq("hit_tbl", bus.hit_tbl, e_htbl);
`ifdef CUCKOO_OCCUPANCY_EN
        check_eq("occ1", bus.occ1, m_occ1);
        check_eq("occ2", bus.occ2, m_occ2);
`endif
        rst_n         = rstn;
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_tbl   = tbl;
        bus.req_key   = key;

        h1 = key % DEPTH;
        h2 = (key / DEPTH) % DEPTH;
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_f1[i] = 0;
                m_f2[i] = 0;
            end
            m_occ1 = 0; m_occ2 = 0;
            e_valid = 0; e_idx = 0; e_ev = 0; e_evk = '0; e_hit = 0; e_htbl = 0;
        end else if (v) begin
            e_valid = 1;
            if (op == 1'b0) begin
                e_hit = 0; e_htbl = 0;
                if (tbl == 1'b0) begin
                    e_idx = h1;
                    e_ev  = m_f1[h1];
                    e_evk = m_f1[h1] ? m_t1[h1] : '0;
                    if (!m_f1[h1]) m_occ1++;
                    m_f1[h1] = 1;
                    m_t1[h1] = key;
                end else begin
                    e_idx = h2;
                    e_ev  = m_f2[h2];
                    e_evk = m_f2[h2] ? m_t2[h2] : '0;
                    if (!m_f2[h2]) m_occ2++;
                    m_f2[h2] = 1;
                    m_t2[h2] = key;
                end
            end else begin
                m1 = m_f1[h1] && (m_t1[h1] == key);
                m2 = m_f2[h2] && (m_t2[h2] == key);
                e_ev = 0; e_evk = '0;
                e_hit  = m1 || m2;
                e_htbl = !m1 && m2;
                e_idx  = m1 ? h1 : (m2 ? h2 : 0);
            end
        end else begin
            e_valid = 0;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_tbl   = 1'b0;
        bus.req_key   = '0;

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        step(1, OP_LOOKUP, 0, 20, 1); idle();
        check_eq("tp_miss_valid", bus.rsp_valid, 1);
        check_eq("tp_miss_hit", bus.hit, 0);
        check_eq("tp_miss_idx", bus.rsp_idx, 0);

        step(1, OP_INSERT, TBL1, 20, 1); idle();
        check_eq("tp_ins20_idx", bus.rsp_idx, 9);
        check_eq("tp_ins20_ev", bus.evict_valid, 0);

        step(1, OP_LOOKUP, 0, 20, 1); idle();
        check_eq("tp_lk20_hit", bus.hit, 1);
        check_eq("tp_lk20_tbl", bus.hit_tbl, 0);
        check_eq("tp_lk20_idx", bus.rsp_idx, 9);

        step(1, OP_INSERT, TBL1, 20, 1);
        step(1, OP_INSERT, TBL1, 53, 1); idle();
        check_eq("tp_b2b_idx", bus.rsp_idx, 9);
        check_eq("tp_b2b_ev", bus.evict_valid, 1);
        check_eq("tp_b2b_evk", bus.evict_key, 20);
        step(1, OP_LOOKUP, 0, 20, 1); idle();
        check_eq("tp_lk20_gone", bus.hit, 0);

        step(1, OP_INSERT, TBL2, 50, 1); idle();
        check_eq("tp_ins50_idx", bus.rsp_idx, 4);
        step(1, OP_INSERT, TBL2, 53, 1); idle();
        check_eq("tp_ins53_evk", bus.evict_key, 50);
        step(1, OP_LOOKUP, 0, 53, 1); idle();
        check_eq("tp_lk53_hit", bus.hit, 1);
        check_eq("tp_lk53_tbl", bus.hit_tbl, 0);

        step(1, OP_INSERT, TBL1, 75, 1);
        step(1, OP_INSERT, TBL1, 6, 1);
        step(1, OP_INSERT, TBL1, 42, 0); idle();
        check_eq("tp_rst_drop", bus.rsp_valid, 0);
        step(1, OP_LOOKUP, 0, 75, 1); idle();
        check_eq("tp_lk75_miss", bus.hit, 0);
`ifdef CUCKOO_OCCUPANCY_EN
        check_eq("tp_occ1_clr", bus.occ1, 0);
`endif
        step(1, OP_INSERT, TBL1, 6, 1); idle();
`ifdef CUCKOO_OCCUPANCY_EN
        check_eq("tp_occ1_one", bus.occ1, 1);
`endif

        step(0, 0, 0, 0, 0);
        step(1, OP_INSERT, TBL1, 9, 1); idle();
        check_eq("tp_ins9_ev", bus.evict_valid, 0);
        step(1, OP_INSERT, TBL2, 20, 1); idle();
        check_eq("tp_ins20t2_ev", bus.evict_valid, 0);
        check_eq("tp_ins20t2_idx", bus.rsp_idx, 1);
        step(1, OP_INSERT, TBL1, 9, 1); idle();
        check_eq("tp_reins9_evk", bus.evict_key, 9);
`ifdef CUCKOO_OCCUPANCY_EN
        check_eq("tp_occ1_same", bus.occ1, 1);
        check_eq("tp_occ2_one", bus.occ2, 1);
`endif

        for (int n = 0; n < 2000; n++) begin
            logic [31:0] k;
            k = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 150);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, k, $urandom_range(0, 99) != 0);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
